// File: rtl/cpu_mem_pkg.sv
// Shared types and address-map helpers for the cpu memory/I-O controller.
package cpu_mem_pkg;

   localparam int unsigned WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic int unsigned io_base(input int unsigned aw, input int unsigned nch);
      return (32'd1 << aw) - nch;
   endfunction

   function automatic logic is_io(input int unsigned a, input int unsigned base);
      return a >= base;
   endfunction

   function automatic int unsigned io_index(input int unsigned a, input int unsigned base);
      return a - base;
   endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// Core-side request/response bus of the memory controller.
interface cpu_mem_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;

   modport master (output req, we, addr, wdata, input rdata, ready);
   modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/cpu_mem_ram.sv
// Single-port synchronous RAM; read data is registered and held while idle.
module cpu_mem_ram #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];

   // Write or read one word per enabled cycle; contents are never reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_r[addr] <= wdata;
         end else begin
            rdata <= mem_r[addr];
         end
      end
   end
endmodule

// File: rtl/cpu_mem_ctrl.sv
// Memory/I-O controller: wait-state FSM, RAM, mapped I/O channels.
// Optional write protection of the low RAM region via `WRITE_PROTECT_EN.
module cpu_mem_ctrl
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 6,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_STATES = 1,
   parameter int IO_CHANNELS = 2,
   parameter int PROTECT_TOP = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   cpu_mem_if.slave                          bus,
   input  logic [IO_CHANNELS*DATA_WIDTH-1:0] io_in,
   input  logic [IO_CHANNELS-1:0]            io_in_valid,
   output logic [IO_CHANNELS-1:0]            io_in_ack,
   output logic [IO_CHANNELS*DATA_WIDTH-1:0] io_out,
   output logic [IO_CHANNELS-1:0]            io_out_valid,
   output logic                              err
);
   localparam int unsigned IO_BASE = io_base(ADDR_WIDTH, IO_CHANNELS);
   localparam logic [WAIT_CNT_W-1:0] CNT_INIT = WAIT_CNT_W'(WAIT_STATES);

   state_t                  state_r, state_nxt_s;
   logic [WAIT_CNT_W-1:0]   cnt_r, cnt_nxt_s;
   logic                    we_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [DATA_WIDTH-1:0]   wdata_r;

   logic                    eff_we_s;
   logic [ADDR_WIDTH-1:0]   eff_addr_s;
   logic [DATA_WIDTH-1:0]   eff_wdata_s;
   logic                    acc_io_s;
   logic [IO_CHANNELS-1:0]  ch_onehot_s;
   logic [DATA_WIDTH-1:0]   io_word_s;
   logic                    stall_s;
   logic                    prot_region_s;
   logic                    prot_s;
   logic                    enter_resp_s;
   logic                    ram_en_s;
   logic [DATA_WIDTH-1:0]   ram_rdata_s;

   logic                    ready_r;
   logic                    err_r;
   logic                    src_ram_r;
   logic [DATA_WIDTH-1:0]   io_rdata_r;
   logic [IO_CHANNELS-1:0]  io_in_ack_r;
   logic [IO_CHANNELS-1:0]  io_out_valid_r;
   logic [IO_CHANNELS*DATA_WIDTH-1:0] io_out_r;

   // In IDLE the live bus is the access being accepted; afterwards the latched copy.
   assign eff_we_s    = (state_r == IDLE) ? bus.we    : we_r;
   assign eff_addr_s  = (state_r == IDLE) ? bus.addr  : addr_r;
   assign eff_wdata_s = (state_r == IDLE) ? bus.wdata : wdata_r;
   assign acc_io_s    = is_io(32'(eff_addr_s), IO_BASE);

   // Channel decode and selected input word.
   always_comb begin
      ch_onehot_s = '0;
      io_word_s   = '0;
      for (int i = 0; i < IO_CHANNELS; i++) begin
         ch_onehot_s[i] = acc_io_s && (io_index(32'(eff_addr_s), IO_BASE) == 32'(i));
         io_word_s      = io_word_s | (io_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{ch_onehot_s[i]}});
      end
   end

   assign stall_s       = acc_io_s && !eff_we_s && ((io_in_valid & ch_onehot_s) == '0);
   assign prot_region_s = !acc_io_s && eff_we_s && (int'(eff_addr_s) < PROTECT_TOP);
`ifdef WRITE_PROTECT_EN
   assign prot_s = prot_region_s;
`else
   assign prot_s = 1'b0 & prot_region_s;
`endif

   // State and wait-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state logic; an I/O read with no input word parks in WAIT.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (bus.req) begin
               if ((WAIT_STATES == 0) && !stall_s) begin
                  state_nxt_s = RESP;
                  cnt_nxt_s   = '0;
               end else begin
                  state_nxt_s = WAIT;
                  cnt_nxt_s   = CNT_INIT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r > 4'd1) begin
               cnt_nxt_s = cnt_r - 4'd1;
            end else begin
               cnt_nxt_s   = '0;
               state_nxt_s = stall_s ? WAIT : RESP;
            end
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   assign enter_resp_s = (state_nxt_s == RESP) && !rst;
   assign ram_en_s     = enter_resp_s && !acc_io_s && !prot_s;

   // Capture the request when it is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
      end else if ((state_r == IDLE) && bus.req) begin
         we_r    <= bus.we;
         addr_r  <= bus.addr;
         wdata_r <= bus.wdata;
      end
   end

   // Response pulses and I/O registers, all updated on the edge entering RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_r        <= 1'b0;
         err_r          <= 1'b0;
         src_ram_r      <= 1'b0;
         io_rdata_r     <= '0;
         io_in_ack_r    <= '0;
         io_out_valid_r <= '0;
         io_out_r       <= '0;
      end else begin
         ready_r        <= enter_resp_s;
         err_r          <= enter_resp_s && prot_s;
         io_in_ack_r    <= (enter_resp_s && !eff_we_s) ? ch_onehot_s : '0;
         io_out_valid_r <= (enter_resp_s &&  eff_we_s) ? ch_onehot_s : '0;
         if (enter_resp_s && !eff_we_s) begin
            src_ram_r <= !acc_io_s;
            if (acc_io_s) begin
               io_rdata_r <= io_word_s;
            end
         end
         for (int i = 0; i < IO_CHANNELS; i++) begin
            if (enter_resp_s && eff_we_s && ch_onehot_s[i]) begin
               io_out_r[i*DATA_WIDTH +: DATA_WIDTH] <= eff_wdata_s;
            end
         end
      end
   end

   cpu_mem_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en_s),
      .we    (eff_we_s),
      .addr  (eff_addr_s),
      .wdata (eff_wdata_s),
      .rdata (ram_rdata_s)
   );

   assign bus.rdata    = src_ram_r ? ram_rdata_s : io_rdata_r;
   assign bus.ready    = ready_r;
   assign io_in_ack    = io_in_ack_r;
   assign io_out       = io_out_r;
   assign io_out_valid = io_out_valid_r;
   assign err          = err_r;
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Directed bench for cpu_mem_ctrl: default instance plus a zero-wait-state instance.
module tb_cpu_mem_ctrl;
   logic clk;
   logic rst;

   cpu_mem_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus0 ();
   cpu_mem_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus1 ();

   logic [31:0] io_in0, io_in1;
   logic [1:0]  io_in_valid0, io_in_valid1;
   logic [1:0]  io_in_ack0, io_in_ack1;
   logic [31:0] io_out0, io_out1;
   logic [1:0]  io_out_valid0, io_out_valid1;
   logic        err0, err1;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_mem_ctrl dut0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .io_in(io_in0), .io_in_valid(io_in_valid0), .io_in_ack(io_in_ack0),
      .io_out(io_out0), .io_out_valid(io_out_valid0), .err(err0)
   );

   cpu_mem_ctrl #(.WAIT_STATES(0), .PROTECT_TOP(0)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .io_in(io_in1), .io_in_valid(io_in_valid1), .io_in_ack(io_in_ack1),
      .io_out(io_out1), .io_out_valid(io_out_valid1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One access on bus0; drives at a negedge, samples at later negedges.
   task automatic access(input logic w, input logic [5:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output int lat, output logic e,
                         output logic [1:0] ack, output logic [1:0] ov);
      logic got;
      got = 1'b0; lat = 0; rd = '0; e = 1'b0; ack = '0; ov = '0;
      @(negedge clk);
      bus0.req = 1'b1; bus0.we = w; bus0.addr = a; bus0.wdata = d;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         bus0.req = 1'b0;
         if (bus0.ready) begin
            got = 1'b1; rd = bus0.rdata; e = err0; ack = io_in_ack0; ov = io_out_valid0;
         end
      end
      check("ready_seen", got, 1);
      @(negedge clk);
      check("pulse_end", {bus0.ready, err0, io_in_ack0, io_out_valid0}, 0);
   endtask

   typedef struct {
      logic        we;
      logic [5:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic [1:0]  exp_ov;
      logic [31:0] exp_io_out;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [15:0] rd, rd_before;
      int          lat, idx;
      logic        e, saw;
      logic [1:0]  ack, ov;
      logic [7:0]  pattern;

      vecs[0] = '{1'b1, 6'd10, 16'h1234, 16'h0000, 2'b00, 32'h0000_0000};
      vecs[1] = '{1'b0, 6'd10, 16'h0000, 16'h1234, 2'b00, 32'h0000_0000};
      vecs[2] = '{1'b1, 6'd40, 16'hABCD, 16'h1234, 2'b00, 32'h0000_0000};
      vecs[3] = '{1'b1, 6'd41, 16'h5555, 16'h1234, 2'b00, 32'h0000_0000};
      vecs[4] = '{1'b0, 6'd40, 16'h0000, 16'hABCD, 2'b00, 32'h0000_0000};
      vecs[5] = '{1'b0, 6'd41, 16'h0000, 16'h5555, 2'b00, 32'h0000_0000};
      vecs[6] = '{1'b1, 6'd63, 16'h00A5, 16'h5555, 2'b10, 32'h00A5_0000};
      vecs[7] = '{1'b0, 6'd10, 16'h0000, 16'h1234, 2'b00, 32'h00A5_0000};
      vecs[8] = '{1'b1, 6'd62, 16'h3C3C, 16'h1234, 2'b01, 32'h00A5_3C3C};
      vecs[9] = '{1'b0, 6'd41, 16'h0000, 16'h5555, 2'b00, 32'h00A5_3C3C};

      rst = 1'b1;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
      bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
      io_in0 = '0; io_in_valid0 = '0; io_in1 = '0; io_in_valid1 = '0;

      repeat (2) @(negedge clk);
      check("reset_outputs0", {bus0.rdata, bus0.ready, io_in_ack0, io_out0, io_out_valid0, err0}, 0);
      check("reset_outputs1", {bus1.rdata, bus1.ready, io_in_ack1, io_out1, io_out_valid1, err1}, 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, e, ack, ov);
         check($sformatf("vec%0d_latency", i), lat, 2);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_io_out_valid", i), ov, vecs[i].exp_ov);
         check($sformatf("vec%0d_io_out", i), io_out0, vecs[i].exp_io_out);
         check($sformatf("vec%0d_ack_err", i), {ack, e}, 0);
      end

      // I/O read stalls until channel 0 has a word; channel 1 valid must not help.
      io_in0 = {16'h1357, 16'h0000};
      io_in_valid0 = 2'b10;
      fork
         access(1'b0, 6'd62, 16'h0000, rd, lat, e, ack, ov);
         begin
            repeat (6) @(negedge clk);
            io_in0 = {16'h1357, 16'hBEEF};
            io_in_valid0 = 2'b11;
         end
      join
      io_in_valid0 = 2'b00;
      check("io_stall_latency", lat, 6);
      check("io_read_rdata", rd, 16'hBEEF);
      check("io_read_ack", ack, 2'b01);
      check("io_read_out_unchanged", io_out0, 32'h00A5_3C3C);

      // Zero wait states, req held high: one completion every second cycle.
      @(negedge clk);
      bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 6'd0; bus1.wdata = 16'hA000;
      idx = 0; pattern = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         pattern[k] = bus1.ready;
         if (bus1.ready) begin
            idx++;
            bus1.addr  = 6'(idx);
            bus1.wdata = 16'hA000 + 16'(idx);
         end
      end
      bus1.req = 1'b0;
      check("b2b_ready_pattern", pattern, 8'b0101_0101);
      check("b2b_count", idx, 4);
      for (int a = 0; a < 4; a++) begin
         @(negedge clk);
         bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 6'(a);
         @(negedge clk);
         bus1.req = 1'b0;
         check($sformatf("b2b_rd%0d_ready", a), bus1.ready, 1);
         check($sformatf("b2b_rd%0d_data", a), bus1.rdata, 16'hA000 + 16'(a));
      end

      // Protected region write.
      access(1'b1, 6'd3, 16'h0042, rd, lat, e, ack, ov);
      access(1'b0, 6'd3, 16'h0000, rd_before, lat, e, ack, ov);
`ifndef WRITE_PROTECT_EN
      check("prot_prior", rd_before, 16'h0042);
`endif
      access(1'b1, 6'd3, 16'hFFFF, rd, lat, e, ack, ov);
      check("prot_latency", lat, 2);
`ifdef WRITE_PROTECT_EN
      check("prot_err", e, 1);
`else
      check("prot_err", e, 0);
`endif
      check("prot_rdata_held", rd, rd_before);
      access(1'b0, 6'd3, 16'h0000, rd, lat, e, ack, ov);
`ifdef WRITE_PROTECT_EN
      check("prot_readback", rd, rd_before);
`else
      check("prot_readback", rd, 16'hFFFF);
`endif

      // Reset during the wait of a write aborts it.
      access(1'b1, 6'd20, 16'h1111, rd, lat, e, ack, ov);
      @(negedge clk);
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 6'd20; bus0.wdata = 16'hDEAD;
      @(negedge clk);
      bus0.req = 1'b0;
      rst = 1'b1;
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         saw = saw | bus0.ready;
      end
      check("rst_abort_ready", saw, 0);
      check("rst_io_out_cleared", io_out0, 32'h0);
      rst = 1'b0;
      access(1'b0, 6'd20, 16'h0000, rd, lat, e, ack, ov);
      check("rst_idle_latency", lat, 2);
      check("rst_no_commit", rd, 16'h1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
